// File: rtl/ov5640_pkg.sv
// rtl/ov5640_pkg.sv - shared state encoding and ROM entry layout for OV5640 init
package ov5640_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWR_WAIT,
        ST_RST_WAIT,
        ST_FETCH,
        ST_LATCH,
        ST_WRITE,
        ST_DELAY,
        ST_DONE,
        ST_ERROR
    } init_state_t;

    localparam logic [15:0] SOFT_RESET_REG = 16'h3008;
    localparam int          REG_ADDR_MSB   = 23;
    localparam int          REG_DATA_MSB   = 7;

    // A sensor soft reset needs settle time before the next register write.
    function automatic logic is_soft_reset(input logic [15:0] addr, input logic [7:0] data);
        return (addr == SOFT_RESET_REG) && data[7];
    endfunction

endpackage

// File: rtl/ov5640_init_delay_cnt.sv
// rtl/ov5640_init_delay_cnt.sv - 24-bit wait counter with terminal flag, zero limit acts as one
module ov5640_init_delay_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [23:0] limit,
    output logic        tc
);

    logic [23:0] cnt;
    logic [23:0] last;

    assign last = (limit == 24'd0) ? 24'd0 : limit - 24'd1;
    assign tc   = en && (cnt == last);

    // Idle or terminal count clears, so every delay state starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 24'd0;
        end else if (!en || tc) begin
            cnt <= 24'd0;
        end else begin
            cnt <= cnt + 24'd1;
        end
    end

endmodule

// File: rtl/ov5640_init_sequencer.sv
// rtl/ov5640_init_sequencer.sv - OV5640 power-up and ROM-driven SCCB init; OV5640_INIT_RETRY_EN enables NACK retry
module ov5640_init_sequencer
    import ov5640_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 8,
    parameter int          INIT_REG_NUM   = 250,
    parameter logic [23:0] PWDN_DELAY     = 24'd120000,
    parameter logic [23:0] RST_DELAY      = 24'd600000,
    parameter logic [23:0] SOFT_RST_DELAY = 24'd300000
`ifdef OV5640_INIT_RETRY_EN
    ,
    parameter int          MAX_RETRY      = 3
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [23:0]           rom_q,
    output logic                  wr_req,
    output logic [15:0]           wr_reg_addr,
    output logic [7:0]            wr_data,
    input  logic                  wr_done,
    input  logic                  wr_nack,
    output logic                  cam_pwdn,
    output logic                  cam_rst_n,
    output logic                  init_busy,
    output logic                  init_done,
    output logic                  init_error
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(INIT_REG_NUM - 1);

    init_state_t state;
    logic        dly_en;
    logic [23:0] dly_limit;
    logic        dly_tc;
    logic        last_entry;
`ifdef OV5640_INIT_RETRY_EN
    logic [1:0]  retry_cnt;
`endif

    assign last_entry = (rom_addr == LAST_ADDR);

    always_comb begin
        dly_en    = 1'b0;
        dly_limit = PWDN_DELAY;
        case (state)
            ST_PWR_WAIT: begin dly_en = 1'b1; dly_limit = PWDN_DELAY;     end
            ST_RST_WAIT: begin dly_en = 1'b1; dly_limit = RST_DELAY;      end
            ST_DELAY:    begin dly_en = 1'b1; dly_limit = SOFT_RST_DELAY; end
            default:     ;
        endcase
    end

    ov5640_init_delay_cnt u_delay_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dly_en),
        .limit (dly_limit),
        .tc    (dly_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rom_addr    <= '0;
            wr_req      <= 1'b0;
            wr_reg_addr <= 16'h0;
            wr_data     <= 8'h0;
            cam_pwdn    <= 1'b1;
            cam_rst_n   <= 1'b0;
            init_busy   <= 1'b0;
            init_done   <= 1'b0;
            init_error  <= 1'b0;
`ifdef OV5640_INIT_RETRY_EN
            retry_cnt   <= 2'd0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        init_done  <= 1'b0;
                        init_error <= 1'b0;
                        init_busy  <= 1'b1;
                        cam_pwdn   <= 1'b0;
                        cam_rst_n  <= 1'b0;
                        state      <= ST_PWR_WAIT;
                    end
                end
                ST_PWR_WAIT: begin
                    if (dly_tc) begin
                        cam_rst_n <= 1'b1;
                        state     <= ST_RST_WAIT;
                    end
                end
                ST_RST_WAIT: begin
                    if (dly_tc) begin
                        rom_addr <= '0;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
`ifdef OV5640_INIT_RETRY_EN
                    retry_cnt <= 2'd0;
`endif
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    wr_reg_addr <= rom_q[REG_ADDR_MSB:REG_DATA_MSB+1];
                    wr_data     <= rom_q[REG_DATA_MSB:0];
                    wr_req      <= 1'b1;
                    state       <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (wr_done) begin
                        wr_req <= 1'b0;
                        if (!wr_nack) begin
                            if (is_soft_reset(wr_reg_addr, wr_data)) begin
                                state <= ST_DELAY;
                            end else if (last_entry) begin
                                init_done <= 1'b1;
                                init_busy <= 1'b0;
                                state     <= ST_DONE;
                            end else begin
                                rom_addr <= rom_addr + 1'b1;
                                state    <= ST_FETCH;
                            end
`ifdef OV5640_INIT_RETRY_EN
                        end else if (retry_cnt != 2'(MAX_RETRY)) begin
                            // rom_addr is unchanged, so LATCH re-reads the same entry.
                            retry_cnt <= retry_cnt + 2'd1;
                            state     <= ST_LATCH;
`endif
                        end else begin
                            init_error <= 1'b1;
                            init_busy  <= 1'b0;
                            state      <= ST_ERROR;
                        end
                    end
                end
                ST_DELAY: begin
                    if (dly_tc) begin
                        if (last_entry) begin
                            init_done <= 1'b1;
                            init_busy <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// tb/tb_ov5640_init_sequencer.sv - scoreboard bench for the OV5640 init sequencer
module tb_ov5640_init_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [23:0] rom_q = 24'h0;
    logic        wr_req;
    logic [15:0] wr_reg_addr;
    logic [7:0]  wr_data;
    logic        wr_done = 1'b0;
    logic        wr_nack = 1'b0;
    logic        cam_pwdn;
    logic        cam_rst_n;
    logic        init_busy;
    logic        init_done;
    logic        init_error;

    always #5 clk = ~clk;

    ov5640_init_sequencer #(
        .ADDR_WIDTH     (8),
        .INIT_REG_NUM   (5),
        .PWDN_DELAY     (24'd4),
        .RST_DELAY      (24'd8),
        .SOFT_RST_DELAY (24'd16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .wr_req      (wr_req),
        .wr_reg_addr (wr_reg_addr),
        .wr_data     (wr_data),
        .wr_done     (wr_done),
        .wr_nack     (wr_nack),
        .cam_pwdn    (cam_pwdn),
        .cam_rst_n   (cam_rst_n),
        .init_busy   (init_busy),
        .init_done   (init_done),
        .init_error  (init_error)
    );

    int total = 0;
    int bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [23:0] rom_tab [0:7] = '{24'h310311, 24'h300882, 24'h300842, 24'h3017ff,
                                   24'h474020, 24'h0, 24'h0, 24'h0};

    always @(negedge clk) rom_q = (rom_addr < 8'd8) ? rom_tab[rom_addr[2:0]] : 24'h0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] sb_q [$];
    int          txn_cnt = 0;
    int          t_start [0:63];
    int          t_done  [0:63];
    int          nack_entry = 99;
    int          nack_budget = 0;
    int          nacks_given = 0;
    bit          sccb_busy = 1'b0;
    int          sccb_timer = 0;
    logic [23:0] cur = 24'h0;
    bit          cur_nack = 1'b0;

    // SCCB slave model: answers each request 10 cycles after it is seen.
    always @(negedge clk) begin
        if (!rst_n) begin
            sccb_busy = 1'b0;
            wr_done   = 1'b0;
            wr_nack   = 1'b0;
        end else begin
            wr_done = 1'b0;
            wr_nack = 1'b0;
            if (sccb_busy) begin
                check_val("bus_stable", {7'd0, wr_req, wr_reg_addr, wr_data}, {8'd1, cur});
                sccb_timer++;
                if (sccb_timer == 10) begin
                    wr_done   = 1'b1;
                    wr_nack   = cur_nack;
                    sccb_busy = 1'b0;
                    if (txn_cnt <= 64) t_done[txn_cnt-1] = cyc;
                end
            end else if (wr_req) begin
                sccb_busy  = 1'b1;
                sccb_timer = 0;
                cur        = {wr_reg_addr, wr_data};
                cur_nack   = (int'(rom_addr) == nack_entry) && (nacks_given < nack_budget);
                if (cur_nack) nacks_given++;
                if (txn_cnt < 64) t_start[txn_cnt] = cyc;
                txn_cnt++;
                check_val("sb_has_entry", {31'd0, sb_q.size() > 0}, 32'd1);
                if (sb_q.size() > 0) check_val("txn", {8'd0, cur}, {8'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_entries(input int first, input int last);
        for (int i = first; i <= last; i++) sb_q.push_back(rom_tab[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (!init_done && !init_error && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("end_in_budget", {31'd0, n < budget}, 32'd1);
    endtask

    task automatic full_walk(input string tag);
        int base;
        base = txn_cnt;
        push_entries(0, 4);
        pulse_start();
        check_val({tag, "_err_clr"}, {31'd0, init_error}, 32'd0);
        check_val({tag, "_pwdn"}, {31'd0, cam_pwdn}, 32'd0);
        check_val({tag, "_rst_hold"}, {31'd0, cam_rst_n}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, init_busy}, 32'd1);
        wait_end(3000);
        check_val({tag, "_done"}, {29'd0, init_done, init_busy, init_error}, 32'b100);
        check_val({tag, "_count"}, txn_cnt - base, 32'd5);
        check_val({tag, "_sb_empty"}, sb_q.size(), 32'd0);
    endtask

    initial begin
        int n;
        int base;

        rst_n = 1'b0;
        tick(3);
        check_val("rst_pwdn", {31'd0, cam_pwdn}, 32'd1);
        check_val("rst_cam_rst_n", {31'd0, cam_rst_n}, 32'd0);
        check_val("rst_req", {31'd0, wr_req}, 32'd0);
        check_val("rst_buses", {rom_addr, wr_reg_addr, wr_data}, 32'd0);
        check_val("rst_flags", {29'd0, init_busy, init_done, init_error}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Power sequence timing and full walk.
        base = txn_cnt;
        push_entries(0, 4);
        pulse_start();
        check_val("pwdn_fall", {31'd0, cam_pwdn}, 32'd0);
        check_val("busy_set", {31'd0, init_busy}, 32'd1);
        n = 0;
        while (!cam_rst_n && n < 50) begin @(negedge clk); n++; end
        check_val("pwdn_to_rst", n, 32'd4);
        n = 0;
        while (!wr_req && n < 50) begin @(negedge clk); n++; end
        check_val("rst_to_first_req", n, 32'd10);
        check_val("first_rom_addr", {24'd0, rom_addr}, 32'd0);
        wait_end(3000);
        check_val("walk_done", {29'd0, init_done, init_busy, init_error}, 32'b100);
        check_val("walk_count", txn_cnt - base, 32'd5);
        check_val("walk_sb_empty", sb_q.size(), 32'd0);
        check_val("softrst_gap_ge16", {31'd0, (t_start[base+2] - t_done[base+1]) >= 16}, 32'd1);
        check_val("plain_gap", t_start[base+3] - t_done[base+2], 32'd3);

        // NACK on entry 3.
        nack_entry = 3;
`ifdef OV5640_INIT_RETRY_EN
        nack_budget = nacks_given + 2;
        base = txn_cnt;
        push_entries(0, 3);
        push_entries(3, 3);
        push_entries(3, 4);
        pulse_start();
        wait_end(3000);
        check_val("retry_ok_done", {29'd0, init_done, init_busy, init_error}, 32'b100);
        check_val("retry_ok_count", txn_cnt - base, 32'd7);
        check_val("retry_ok_sb_empty", sb_q.size(), 32'd0);

        nack_budget = nacks_given + 4;
        base = txn_cnt;
        push_entries(0, 3);
        push_entries(3, 3);
        push_entries(3, 3);
        push_entries(3, 3);
        pulse_start();
        wait_end(3000);
        n = 7;
`else
        nack_budget = nacks_given + 1;
        base = txn_cnt;
        push_entries(0, 3);
        pulse_start();
        wait_end(3000);
        n = 4;
`endif
        check_val("nack_error", {29'd0, init_done, init_busy, init_error}, 32'b001);
        check_val("nack_rom_addr", {24'd0, rom_addr}, 32'd3);
        tick(40);
        check_val("nack_no_more_txn", txn_cnt - base, n);
        check_val("nack_req_low", {31'd0, wr_req}, 32'd0);
        check_val("nack_sb_empty", sb_q.size(), 32'd0);

        nack_budget = nacks_given;
        full_walk("restart");

        // Stray start while busy, then reset in the middle of entry 2.
        base = txn_cnt;
        push_entries(0, 4);
        pulse_start();
        n = 0;
        while (txn_cnt - base < 3 && n < 3000) begin @(negedge clk); n++; end
        check_val("reach_entry2", {31'd0, n < 3000}, 32'd1);
        tick(2);
        pulse_start();
        tick(1);
        check_val("stray_count", txn_cnt - base, 32'd3);
        check_val("stray_state", {29'd0, wr_req, cam_rst_n, init_busy}, 32'b111);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_req", {31'd0, wr_req}, 32'd0);
        check_val("arst_pins", {30'd0, cam_pwdn, cam_rst_n}, 32'b10);
        check_val("arst_flags", {29'd0, init_busy, init_done, init_error}, 32'd0);
        sb_q.delete();
        tick(3);
        rst_n = 1'b1;
        tick(30);
        check_val("post_rst_idle", {29'd0, wr_req, init_done, init_busy}, 32'd0);
        check_val("post_rst_count", txn_cnt - base, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
